// File: rtl/cla_nibble_seq_adder_if.sv
// ---------------------------------------------------------------------------
// cla_nibble_seq_adder_if
//   Request/result bundle for the nibble-serial CLA adder.
//
//   Signals (W = operand width = 4*NIBBLES of the attached adder):
//     start  request, sampled by the adder only in IDLE or DONE
//     a, b   operands, captured on the edge that accepts start
//     sub    subtract select (only when CLA_SEQ_SUB_EN is defined)
//     busy   high while the adder is stepping through nibbles
//     done   one-cycle pulse when sum/cout are valid
//     sum    result register
//     cout   carry out of the top nibble (no-borrow flag when subtracting)
//
//   Modports: master drives the request side, slave is the adder.
//   Optional feature macro: CLA_SEQ_SUB_EN (adds the sub signal).
// ---------------------------------------------------------------------------
interface cla_nibble_seq_adder_if #(
  parameter int unsigned W = 16
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef CLA_SEQ_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef CLA_SEQ_SUB_EN
  modport master (
    output start, a, b, sub,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, cout
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
`endif

endinterface

// File: rtl/cla_nibble_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_nibble_seq_adder
//   Multi-cycle wide adder. A single 4-bit carry-lookahead slice is applied
//   to the operands one nibble per clock, least-significant nibble first;
//   the slice carry-out is registered and fed back as the next carry-in.
//   ADD lasts exactly NIBBLES cycles; done pulses for one cycle afterwards.
//
//   Parameters:
//     NIBBLES  number of 4-bit slices (>= 1); operand width W = 4*NIBBLES
//
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous, active-high reset
//     bus  cla_nibble_seq_adder_if.slave (start, a, b, [sub], busy, done,
//          sum, cout); busy/done/sum/cout are all registered
//
//   Optional feature macro: CLA_SEQ_SUB_EN
//     defined   -> sub latched with operands; sub=1 computes A-B by
//                  inverting B per nibble and presetting carry to 1;
//                  cout=1 then means no borrow (A >= B)
//     undefined -> add only, carry preset to 0
// ---------------------------------------------------------------------------
module cla_nibble_seq_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input logic                     clk,
  input logic                     rst,
  cla_nibble_seq_adder_if.slave   bus
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}
  function automatic logic [4:0] cla4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       c4;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, p ^ c};
  endfunction

  state_t        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sub_in;
  logic          sub_q, sub_d;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [4:0]    slice;
  logic          last_nib;

`ifdef CLA_SEQ_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Select the active operand nibbles; B is inverted when subtracting
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < int'(NIBBLES); n++) begin
      if (idx_q == IW'(n)) begin
        nib_a = opa_q[4*n +: 4];
        nib_b = opb_q[4*n +: 4];
      end
    end
    if (sub_q) begin
      nib_b = ~nib_b;
    end
  end

  assign slice    = cla4(nib_a, nib_b, carry_q);
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  // Registers: FSM state plus datapath, all cleared by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sub_q   <= sub_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sub_d   = sub_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          // Accept: latch operands, clear result, preset carry for A-B
          state_d = S_ADD;
          opa_d   = bus.a;
          opb_d   = bus.b;
          sub_d   = sub_in;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          carry_d = sub_in;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADD: begin
        for (int n = 0; n < int'(NIBBLES); n++) begin
          if (idx_q == IW'(n)) begin
            sum_d[4*n +: 4] = slice[3:0];
          end
        end
        carry_d = slice[4];
        idx_d   = idx_q + IW'(1);
        if (last_nib) begin
          cout_d  = slice[4];
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the upcoming state
    busy_d = (state_d == S_ADD);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
